// File: rtl/sbox_rnd_sched_pkg.sv
// sbox_rnd_sched_pkg: widths and set layout shared by the randomness scheduler files.
//   D         number of shares
//   HPC2_RND  fresh bits per HPC2 gadget = D*(D-1)/2
//   RND_Bk    width of randomness bus k
//   RND_TOT   width of one full randomness set
//   rnd_set_t one set, packed {b3,b2,b1,b0} with b0 in the LSBs
package sbox_rnd_sched_pkg;
   localparam int D        = 2;
   localparam int HPC2_RND = D * (D - 1) / 2;
   localparam int RND_B0   = 9 * HPC2_RND;
   localparam int RND_B1   = 3 * HPC2_RND;
   localparam int RND_B2   = 4 * HPC2_RND;
   localparam int RND_B3   = 18 * HPC2_RND;
   localparam int RND_TOT  = RND_B0 + RND_B1 + RND_B2 + RND_B3;
   localparam int SB_LAT   = 4;
   typedef struct packed {
      logic [RND_B3-1:0] b3;
      logic [RND_B2-1:0] b2;
      logic [RND_B1-1:0] b1;
      logic [RND_B0-1:0] b0;
   } rnd_set_t;
endpackage

// File: rtl/sbox_rnd_sched_if.sv
// sbox_rnd_sched_if: PRNG stream, S-box start and per-stage randomness buses.
//   in_rnd_valid/in_rnd_ready/in_rnd_data  PRNG valid/ready stream, one full set per beat
//   sb_start                               S-box consumes stage-0 inputs this cycle
//   rnd_avail                              at least one set buffered
//   rnd_bus0w..rnd_bus3w                   stage 0..3 randomness
//   err_underrun                           sticky start-without-randomness flag
//   master: PRNG/controller side, slave: scheduler side
interface sbox_rnd_sched_if;
   import sbox_rnd_sched_pkg::*;
   logic              in_rnd_valid;
   logic              in_rnd_ready;
   rnd_set_t          in_rnd_data;
   logic              sb_start;
   logic              rnd_avail;
   logic [RND_B0-1:0] rnd_bus0w;
   logic [RND_B1-1:0] rnd_bus1w;
   logic [RND_B2-1:0] rnd_bus2w;
   logic [RND_B3-1:0] rnd_bus3w;
   logic              err_underrun;
   modport master (
      output in_rnd_valid, in_rnd_data, sb_start,
      input  in_rnd_ready, rnd_avail, rnd_bus0w, rnd_bus1w, rnd_bus2w, rnd_bus3w, err_underrun
   );
   modport slave (
      input  in_rnd_valid, in_rnd_data, sb_start,
      output in_rnd_ready, rnd_avail, rnd_bus0w, rnd_bus1w, rnd_bus2w, rnd_bus3w, err_underrun
   );
endinterface

// File: rtl/sbox_rnd_sched_fifo.sv
// rnd_fifo: register-based FIFO with occupancy count and combinational head output.
//   clk      clock
//   rst_n    asynchronous active-low reset, empties FIFO and clears storage
//   i_push   write i_data (caller guarantees not full unless popping)
//   i_pop    drop head (caller guarantees not empty)
//   i_data   write data
//   o_head   current head entry, no output register
//   o_count  number of stored entries
module rnd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_push,
   input  logic                           i_pop,
   input  logic [W-1:0]                   i_data,
   output logic [W-1:0]                   o_head,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   // Storage is cleared too so the head reads zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (i_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end
   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;
endmodule

// File: rtl/sbox_rnd_sched.sv
// sbox_rnd_sched: buffers PRNG randomness sets and presents each bus in the S-box stage that consumes it.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of sbox_rnd_sched_if (PRNG stream, sb_start, rnd_avail, rnd_bus0w..3w, err_underrun)
//   FIFO_D number of buffered sets (power of 2, >=2)
module sbox_rnd_sched
   import sbox_rnd_sched_pkg::*;
#(
   parameter int FIFO_D = 2
) (
   input logic             clk,
   input logic             rst_n,
   sbox_rnd_sched_if.slave bus
);
   localparam int CW = $clog2(FIFO_D + 1);
   rnd_set_t          w_head;
   logic [CW-1:0]     w_count;
   logic              w_avail;
   logic              w_pop;
   logic              w_push;
   logic [RND_B1-1:0] r_s1_b1;
   logic [RND_B2-1:0] r_s1_b2;
   logic [RND_B3-1:0] r_s1_b3;
   logic [RND_B2-1:0] r_s2_b2;
   logic [RND_B3-1:0] r_s2_b3;
   logic [RND_B3-1:0] r_s3_b3;
   logic              r_v1;
   logic              r_v2;
   logic              r_err;
   assign w_avail          = w_count != '0;
   assign w_pop            = bus.sb_start & w_avail;
   // A pop frees a slot this cycle, so a full FIFO can still accept.
   assign bus.in_rnd_ready = (w_count < CW'(FIFO_D)) | w_pop;
   assign w_push           = bus.in_rnd_valid & bus.in_rnd_ready;
   rnd_fifo #(.W(RND_TOT), .DEPTH(FIFO_D)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (bus.in_rnd_data),
      .o_head  (w_head),
      .o_count (w_count)
   );
   // Stages shift only when the previous stage holds a fresh op, so idle
   // cycles leave the buses untouched. An underrun pushes an all-zero op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_b1 <= '0;
         r_s1_b2 <= '0;
         r_s1_b3 <= '0;
         r_s2_b2 <= '0;
         r_s2_b3 <= '0;
         r_s3_b3 <= '0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (bus.sb_start) begin
            r_s1_b1 <= w_avail ? w_head.b1 : '0;
            r_s1_b2 <= w_avail ? w_head.b2 : '0;
            r_s1_b3 <= w_avail ? w_head.b3 : '0;
         end
         if (r_v1) begin
            r_s2_b2 <= r_s1_b2;
            r_s2_b3 <= r_s1_b3;
         end
         if (r_v2) r_s3_b3 <= r_s2_b3;
         r_v1 <= bus.sb_start;
         r_v2 <= r_v1;
         if (bus.sb_start & !w_avail) r_err <= 1'b1;
      end
   end
   assign bus.rnd_avail    = w_avail;
   assign bus.rnd_bus0w    = w_head.b0;
   assign bus.rnd_bus1w    = r_s1_b1;
   assign bus.rnd_bus2w    = r_s2_b2;
   assign bus.rnd_bus3w    = r_s3_b3;
   assign bus.err_underrun = r_err;
endmodule

// File: tb/tb_sbox_rnd_sched.sv
// tb_sbox_rnd_sched: directed bench for sbox_rnd_sched.
module tb_sbox_rnd_sched;
   import sbox_rnd_sched_pkg::*;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   sbox_rnd_sched_if ifc ();
   sbox_rnd_sched #(.FIFO_D(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );
   function automatic rnd_set_t mk(input int n);
      rnd_set_t s;
      s.b0 = RND_B0'(9'h0A5 ^ n);
      s.b1 = RND_B1'(n + 1);
      s.b2 = RND_B2'(3 * n + 5);
      s.b3 = RND_B3'(18'h25A00 + 7 * n);
      return s;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic v, input rnd_set_t d, input logic st);
      ifc.in_rnd_valid = v;
      ifc.in_rnd_data  = d;
      ifc.sb_start     = st;
      #1;
   endtask
   task automatic tick;
      @(posedge clk);
      #2;
   endtask
   initial begin
      rnd_set_t a, s, f0, f1, f2, g, h, j;
      a  = mk(50);
      f0 = mk(30);
      f1 = mk(31);
      f2 = mk(32);
      g  = mk(40);
      h  = mk(60);
      j  = mk(61);
      drive(1'b0, '0, 1'b0);
      repeat (3) tick;
      rst_n = 1'b1;
      // 1: idle after reset
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("rst_avail", 64'(ifc.rnd_avail), 64'd0);
         chk("rst_ready", 64'(ifc.in_rnd_ready), 64'd1);
         chk("rst_buses", 64'({ifc.rnd_bus3w, ifc.rnd_bus2w, ifc.rnd_bus1w, ifc.rnd_bus0w}), 64'd0);
         chk("rst_err", 64'(ifc.err_underrun), 64'd0);
         tick;
      end
      // 2: single set A
      drive(1'b1, a, 1'b0);
      chk("a_ready", 64'(ifc.in_rnd_ready), 64'd1);
      chk("a_avail0", 64'(ifc.rnd_avail), 64'd0);
      tick;
      drive(1'b0, '0, 1'b1);
      chk("a_avail1", 64'(ifc.rnd_avail), 64'd1);
      chk("a_bus0", 64'(ifc.rnd_bus0w), 64'(a.b0));
      tick;
      drive(1'b0, '0, 1'b0);
      chk("a_bus1", 64'(ifc.rnd_bus1w), 64'(a.b1));
      tick;
      chk("a_bus2", 64'(ifc.rnd_bus2w), 64'(a.b2));
      tick;
      chk("a_bus3", 64'(ifc.rnd_bus3w), 64'(a.b3));
      tick;
      tick;
      #1;
      chk("a_hold1", 64'(ifc.rnd_bus1w), 64'(a.b1));
      chk("a_hold2", 64'(ifc.rnd_bus2w), 64'(a.b2));
      chk("a_hold3", 64'(ifc.rnd_bus3w), 64'(a.b3));
      tick;
      // 3: back-to-back, one start per cycle for 20 ops
      for (int c = 0; c < 24; c++) begin
         drive(c < 20, (c < 20) ? mk(c) : rnd_set_t'('0), (c >= 1) && (c <= 20));
         if (c < 20) chk("bb_ready", 64'(ifc.in_rnd_ready), 64'd1);
         if ((c >= 1) && (c <= 20)) begin
            chk("bb_avail", 64'(ifc.rnd_avail), 64'd1);
            chk("bb_bus0", 64'(ifc.rnd_bus0w), 64'(mk(c - 1).b0));
         end
         if ((c >= 2) && (c <= 21)) begin
            s = mk(c - 2);
            chk("bb_bus1", 64'(ifc.rnd_bus1w), 64'(s.b1));
         end
         if ((c >= 3) && (c <= 22)) begin
            s = mk(c - 3);
            chk("bb_bus2", 64'(ifc.rnd_bus2w), 64'(s.b2));
         end
         if (c >= 4) begin
            s = mk(c - 4);
            chk("bb_bus3", 64'(ifc.rnd_bus3w), 64'(s.b3));
         end
         tick;
      end
      // 4: full FIFO, push and pop together
      drive(1'b1, f0, 1'b0);
      tick;
      drive(1'b1, f1, 1'b0);
      tick;
      drive(1'b1, mk(33), 1'b0);
      chk("full_ready", 64'(ifc.in_rnd_ready), 64'd0);
      chk("full_avail", 64'(ifc.rnd_avail), 64'd1);
      tick;
      drive(1'b1, f2, 1'b1);
      chk("full_pop_ready", 64'(ifc.in_rnd_ready), 64'd1);
      chk("full_bus0_f0", 64'(ifc.rnd_bus0w), 64'(f0.b0));
      tick;
      drive(1'b1, mk(34), 1'b0);
      chk("still_full", 64'(ifc.in_rnd_ready), 64'd0);
      chk("full_bus0_f1", 64'(ifc.rnd_bus0w), 64'(f1.b0));
      chk("full_bus1_f0", 64'(ifc.rnd_bus1w), 64'(f0.b1));
      tick;
      drive(1'b0, '0, 1'b1);
      chk("drain_bus0_f1", 64'(ifc.rnd_bus0w), 64'(f1.b0));
      tick;
      drive(1'b0, '0, 1'b1);
      chk("drain_bus0_f2", 64'(ifc.rnd_bus0w), 64'(f2.b0));
      chk("drain_bus1_f1", 64'(ifc.rnd_bus1w), 64'(f1.b1));
      tick;
      drive(1'b0, '0, 1'b0);
      chk("drain_empty", 64'(ifc.rnd_avail), 64'd0);
      chk("drain_bus1_f2", 64'(ifc.rnd_bus1w), 64'(f2.b1));
      chk("drain_bus2_f1", 64'(ifc.rnd_bus2w), 64'(f1.b2));
      tick;
      // 5: underrun, with a simultaneous push into the empty FIFO
      drive(1'b1, g, 1'b1);
      chk("ur_avail", 64'(ifc.rnd_avail), 64'd0);
      chk("ur_ready", 64'(ifc.in_rnd_ready), 64'd1);
      chk("ur_err0", 64'(ifc.err_underrun), 64'd0);
      tick;
      drive(1'b0, '0, 1'b0);
      chk("ur_err1", 64'(ifc.err_underrun), 64'd1);
      chk("ur_bus1", 64'(ifc.rnd_bus1w), 64'd0);
      chk("ur_g_avail", 64'(ifc.rnd_avail), 64'd1);
      tick;
      chk("ur_bus2", 64'(ifc.rnd_bus2w), 64'd0);
      tick;
      drive(1'b0, '0, 1'b1);
      chk("ur_bus3", 64'(ifc.rnd_bus3w), 64'd0);
      chk("ur_g_bus0", 64'(ifc.rnd_bus0w), 64'(g.b0));
      tick;
      drive(1'b0, '0, 1'b0);
      chk("ur_g_bus1", 64'(ifc.rnd_bus1w), 64'(g.b1));
      chk("ur_sticky", 64'(ifc.err_underrun), 64'd1);
      tick;
      chk("ur_g_bus2", 64'(ifc.rnd_bus2w), 64'(g.b2));
      tick;
      // 6: reset while an op is in flight
      drive(1'b1, h, 1'b0);
      tick;
      drive(1'b0, '0, 1'b1);
      chk("h_bus0", 64'(ifc.rnd_bus0w), 64'(h.b0));
      tick;
      drive(1'b0, '0, 1'b0);
      chk("h_bus1", 64'(ifc.rnd_bus1w), 64'(h.b1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_buses", 64'({ifc.rnd_bus3w, ifc.rnd_bus2w, ifc.rnd_bus1w, ifc.rnd_bus0w}), 64'd0);
      chk("mid_rst_avail", 64'(ifc.rnd_avail), 64'd0);
      chk("mid_rst_err", 64'(ifc.err_underrun), 64'd0);
      chk("mid_rst_ready", 64'(ifc.in_rnd_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      drive(1'b1, j, 1'b0);
      tick;
      drive(1'b0, '0, 1'b1);
      chk("j_bus0", 64'(ifc.rnd_bus0w), 64'(j.b0));
      tick;
      drive(1'b0, '0, 1'b0);
      chk("j_bus1", 64'(ifc.rnd_bus1w), 64'(j.b1));
      tick;
      chk("j_bus2", 64'(ifc.rnd_bus2w), 64'(j.b2));
      tick;
      chk("j_bus3", 64'(ifc.rnd_bus3w), 64'(j.b3));
      chk("j_err", 64'(ifc.err_underrun), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
